ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M/RV64M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the EX stage.
- Takes operands and rd from ID/EX through a valid/ready handshake, iterates one bit per cycle, and presents the result and rd to EX/MEM through a second handshake.
- Honours the global `rdy` pause and a pipeline flush.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  kill in-flight op (branch mispredict/jump)
- in_valid  in  1  op presented
- in_ready  out  1  unit can accept
- op  in  3  funct3 encoding, `MD_MUL..`MD_REMU
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- rd_in  in  5  destination register
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  rd write data
- rd_out  out  5  destination register
- busy  out  1  state != IDLE, used for the hazard stall

Behaviour:
- Reset is synchronous and active-high: on a rising clk edge with rst=1, state=IDLE, counter=0, out_valid=0, result=0, rd_out=0. in_ready=0 while rst=1.
- rst has priority over rdy and flush.
- When rdy=0 (and rst=0), no register changes and no handshake completes.
- States:
  - IDLE: in_ready=1. On in_valid, go to BUSY, or to DONE directly for a special case.
  - BUSY: iterate; counter counts down from XLEN.
  - DONE: out_valid=1, result and rd_out held stable until out_ready.
- Accept rule: accept when in_valid & in_ready & rdy & !flush. in_ready = (state==IDLE) | (state==DONE & out_ready).
  - This allows back-to-back ops: on a DONE handoff and a new accept in the same cycle, the new op is loaded and the result is replaced.
- Signedness:
  - Operands are converted to magnitudes per op: MULH and DIV/REM treat A and B as signed; MULHSU treats A as signed, B as unsigned; MULHU and DIVU/REMU treat both as unsigned.
  - Negation of the result is applied at DONE entry.
  - DIV quotient sign = sign(A) xor sign(B). REM sign = sign(A).
- Multiply: shift-add over a 2*XLEN product register, XLEN iterations.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per iteration, XLEN iterations.
- Latency, counting the accept edge as edge 0 with rdy held high: out_valid rises after edge XLEN+1 (edge 33 for XLEN=32). rdy-low cycles extend it 1:1.
- Special cases bypass BUSY and rise after edge 1:
  - Divide by zero: quotient = all ones; remainder = A.
  - Signed overflow (A = most negative, B = -1): quotient = A; remainder = 0.
  - rs2_data = 0 on a multiply op: result 0.
- flush=1 (rdy=1): next state IDLE, out_valid=0, and no accept that cycle. Flush in DONE discards the held result.
- Operand changes on the inputs after accept have no effect; operands are latched.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a single-cycle XLEN x XLEN combinational multiplier and enter DONE after edge 1; divide is unchanged.
- Undefined: iterative multiply as above, with no DSP inference.
- Handshake, flush and rdy semantics are identical in both builds.

Decomposition:
- Shared header config.v:
  - `MD_MUL=3'b000, `MD_MULH=3'b001, `MD_MULHSU=3'b010, `MD_MULHU=3'b011, `MD_DIV=3'b100, `MD_DIVU=3'b101, `MD_REM=3'b110, `MD_REMU=3'b111
  - state encodings `MD_IDLE/`MD_BUSY/`MD_DONE
  - existing `ResetEnable, `ZeroWord
- Natural sub-module ex_muldiv_core: the shared iterative shift datapath, with start/step inputs and a done flag.
- The top handles handshake, sign fix-up and special cases.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), XLEN=32 -> result 0xFFFFFFEB; out_valid exactly 33 edges after accept. Fast build: 1 edge.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid after edge 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Pause, hold and flush:
  - rdy low for 4 cycles mid-BUSY -> latency 37.
  - out_ready low 3 cycles in DONE -> result/rd_out stable, in_ready=0.
  - flush at edge 10 -> no out_valid, in_ready=1 next cycle.
- Back-to-back: DONE with out_ready=1 and in_valid=1 (DIVU 9/3, rd=5) in the same cycle -> first result consumed; second accepted; result 3 on rd_out=5 after edge 33.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared opcode encodings, FSM states and operand-signedness helpers for the
// RV32M/RV64M multiply/divide execute unit.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX request and EX/MEM result handshakes of the multiply/divide unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            busy;

  modport master (
    output in_valid, op, rs1_data, rs2_data, rd_in, out_ready,
    input  in_ready, out_valid, result, rd_out, busy
  );

  modport slave (
    input  in_valid, op, rs1_data, rs2_data, rd_in, out_ready,
    output in_ready, out_valid, result, rd_out, busy
  );
endinterface

// File: rtl/ex_muldiv_core.sv
// Shared one-bit-per-cycle datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. acc holds {hi,lo} product or {remainder,quotient}.
module ex_muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic              done
);
  logic [CNT_W-1:0]  cnt;
  logic              div_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN:0]     mul_hi;
  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] acc_n;

  assign done = (cnt == '0);

  always_comb begin
    mul_hi = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    trial  = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, b_q};
    acc_n  = {mul_hi, acc[XLEN-1:1]};
    if (div_q) begin
      // Keep the trial difference only when it did not borrow.
      if (!trial[XLEN+1]) acc_n = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                acc_n = {acc[2*XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (start)         cnt <= CNT_W'(XLEN);
    else if (step && !done) cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc   <= {{XLEN{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
    end else if (step && !done) begin
      acc   <= acc_n;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// RV32M/RV64M multiply/divide unit: handshake FSM, sign fix-up, special cases.
// Build option MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MUL*.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  ex_muldiv_if.slave     io
);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state, state_n;
  logic              accept, step;
  logic              a_neg, b_neg, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val, fix_val;
  logic [2:0]        op_q;
  logic              neg_q, neg_rem_q, spec_q;
  logic [XLEN-1:0]   spec_val_q;
  logic [4:0]        rd_q;
  logic [2*XLEN-1:0] acc;
  logic              core_done;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic n,
                                               input logic [2:0] op);
    logic [2*XLEN-1:0] ps;
    ps = n ? -p : p;
    return (op == MD_MUL) ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN];
  endfunction

  assign io.in_ready  = !rst && ((state == MD_IDLE) || ((state == MD_DONE) && io.out_ready));
  assign io.out_valid = (state == MD_DONE);
  assign io.busy      = (state != MD_IDLE);
  assign accept       = io.in_valid && io.in_ready && rdy && !flush;
  assign step         = rdy && (state == MD_BUSY) && !spec_q;

  always_comb begin
    is_div      = op_is_div(io.op);
    a_neg       = op_a_signed(io.op) && io.rs1_data[XLEN-1];
    b_neg       = op_b_signed(io.op) && io.rs2_data[XLEN-1];
    a_mag       = cond_neg(io.rs1_data, a_neg);
    b_mag       = cond_neg(io.rs2_data, b_neg);
    div_zero    = is_div && (io.rs2_data == '0);
    div_ovf     = is_div && op_b_signed(io.op) && (io.rs1_data == MOST_NEG) && (io.rs2_data == '1);
    special     = (io.rs2_data == '0) || div_ovf;
    special_val = '0;
    if (div_zero)     special_val = op_is_rem(io.op) ? io.rs1_data : '1;
    else if (div_ovf) special_val = op_is_rem(io.op) ? '0 : io.rs1_data;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    if (!is_div) begin
      special     = 1'b1;
      special_val = mul_pick(fast_prod, a_neg ^ b_neg, io.op);
    end
`endif
  end

  always_comb begin
    fix_val = mul_pick(acc, neg_q, op_q);
    if (op_is_rem(op_q))      fix_val = cond_neg(acc[2*XLEN-1:XLEN], neg_rem_q);
    else if (op_is_div(op_q)) fix_val = cond_neg(acc[XLEN-1:0], neg_q);
  end

  always_comb begin
    state_n = state;
    if (rdy) begin
      if (flush) state_n = MD_IDLE;
      else begin
        case (state)
          MD_IDLE: if (accept) state_n = MD_BUSY;
          MD_BUSY: if (spec_q || core_done) state_n = MD_DONE;
          MD_DONE: begin
            if (accept)            state_n = MD_BUSY;
            else if (io.out_ready) state_n = MD_IDLE;
          end
          default: state_n = MD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_n;
  end

  // Accept edge: latch op context so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= io.op;
      neg_q      <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      spec_q     <= special;
      spec_val_q <= special_val;
      rd_q       <= io.rd_in;
    end
  end

  // DONE entry: sign-corrected result presented to EX/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.result <= '0;
      io.rd_out <= '0;
    end else if ((state == MD_BUSY) && (state_n == MD_DONE)) begin
      io.result <= spec_q ? spec_val_q : fix_val;
      io.rd_out <= rd_q;
    end
  end

  ex_muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .step   (step),
    .is_div (is_div),
    .a      (a_mag),
    .b      (b_mag),
    .acc    (acc),
    .done   (core_done)
  );
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (XLEN=32): arithmetic, special cases, latency,
// rdy pause, result hold, flush and back-to-back handoff.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst, rdy, flush;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_if #(.XLEN(XLEN)) io();

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for the accept edge, then scrambles the operand inputs.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    io.in_valid = 1'b1;
    io.op       = op;
    io.rs1_data = a;
    io.rs2_data = b;
    io.rd_in    = rd;
    tick();
    io.in_valid = 1'b0;
    io.rs1_data = ~a;
    io.rs2_data = ~b;
    io.rd_in    = ~rd;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (io.out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    io.in_valid = 1'b0; io.out_ready = 1'b0; io.op = MD_MUL;
    io.rs1_data = '0; io.rs2_data = '0; io.rd_in = '0;
    tick(); tick();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", io.result); end
    checks++; if (io.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got=%0d exp=0", io.rd_out); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", io.busy); end
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_in_rst got=%b exp=0", io.in_ready); end
    rst = 1'b0;
    tick();
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", io.in_ready); end
  endtask

  task automatic test_arith();
    string       names [8] = '{"mul", "mulh", "mulhu", "mulhsu", "div", "rem", "divu", "remu"};
    logic [2:0]  ops   [8] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM, MD_DIVU, MD_REMU};
    logic [31:0] as    [8] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs    [8] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps  [8] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int          lats  [8] = '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT, 33, 33, 33, 33};
    int n;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i], 5'(i + 1));
      wait_valid(n);
      checks++; if (io.result !== exps[i]) begin errors++; $display("FAIL %s_result got=%h exp=%h", names[i], io.result, exps[i]); end
      checks++; if (n != lats[i]) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", names[i], n, lats[i]); end
      checks++; if (io.rd_out !== 5'(i + 1)) begin errors++; $display("FAIL %s_rd got=%0d exp=%0d", names[i], io.rd_out, i + 1); end
      consume();
    end
  endtask

  task automatic test_special();
    string       names [5] = '{"div_by_zero", "rem_by_zero", "div_ovf", "rem_ovf", "mul_by_zero"};
    logic [2:0]  ops   [5] = '{MD_DIV, MD_REM, MD_DIV, MD_REM, MD_MULH};
    logic [31:0] as    [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] bs    [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] exps  [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0};
    int n;
    for (int i = 0; i < 5; i++) begin
      start_op(ops[i], as[i], bs[i], 5'd20);
      wait_valid(n);
      checks++; if (io.result !== exps[i]) begin errors++; $display("FAIL %s_result got=%h exp=%h", names[i], io.result, exps[i]); end
      checks++; if (n != 1) begin errors++; $display("FAIL %s_latency got=%0d exp=1", names[i], n); end
      consume();
    end
  endtask

  task automatic test_pause();
    int n = 0;
    start_op(MD_DIVU, 32'd100, 32'd7, 5'd6);
    while (io.out_valid !== 1'b1 && n < 200) begin
      rdy = !(n >= 5 && n < 9);
      tick();
      n++;
    end
    rdy = 1'b1;
    checks++; if (n != 37) begin errors++; $display("FAIL pause_latency got=%0d exp=37", n); end
    checks++; if (io.result !== 32'd14) begin errors++; $display("FAIL pause_result got=%h exp=0000000e", io.result); end
    consume();
  endtask

  task automatic test_hold();
    int n;
    start_op(MD_DIVU, 32'd100, 32'd7, 5'd9);
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (io.result !== 32'd14 || io.rd_out !== 5'd9) begin
        errors++; $display("FAIL hold_data got=%h/%0d exp=0000000e/9", io.result, io.rd_out);
      end
      checks++; if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_handshake out_valid=%b in_ready=%b exp=1/0", io.out_valid, io.in_ready);
      end
    end
    consume();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", io.out_valid); end
  endtask

  task automatic test_flush();
    int seen = 0;
    start_op(MD_DIVU, 32'd100, 32'd7, 5'd4);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin
      errors++; $display("FAIL flush_state out_valid=%b busy=%b exp=0/0", io.out_valid, io.busy);
    end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", io.in_ready); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (io.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(MD_DIVU, 32'd100, 32'd7, 5'd3);
    wait_valid(n);
    io.out_ready = 1'b1;
    start_op(MD_DIVU, 32'd9, 32'd3, 5'd5);
    io.out_ready = 1'b0;
    checks++; if (io.out_valid !== 1'b0 || io.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_handoff out_valid=%b busy=%b exp=0/1", io.out_valid, io.busy);
    end
    wait_valid(n);
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", n); end
    checks++; if (io.result !== 32'd3 || io.rd_out !== 5'd5) begin
      errors++; $display("FAIL b2b_result got=%h/%0d exp=00000003/5", io.result, io.rd_out);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_pause();
    test_hold();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
